// File: rtl/memory_stage_banked_if.sv
// memory_stage_banked_if: shared bank bus between the memory stage and its external bank RAMs
interface memory_stage_banked_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NUM_BANKS = 3
);
  logic [NUM_BANKS*ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wdata;
  logic [NUM_BANKS-1:0] bank_wren;
  logic [NUM_BANKS-1:0] bank_rden;
  logic [NUM_BANKS*DATA_W-1:0] bank_q;
  modport master (output bank_addr, bank_wdata, bank_wren, bank_rden, input bank_q);
  modport slave (input bank_addr, bank_wdata, bank_wren, bank_rden, output bank_q);
endinterface

// File: rtl/memory_stage_banked.sv
// memory_stage_banked: EX/MEM register, N-way bank decoder and MEM/WB register of the image CPU
module memory_stage_banked #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NUM_BANKS = 3,
  parameter int SEL_W = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_in,
  input  logic flush_in,
  input  logic ex_valid,
  input  logic ex_wbs,
  input  logic [SEL_W-1:0] ex_bank_sel,
  input  logic ex_mem_rd,
  input  logic ex_mem_wr,
  input  logic ex_wm,
  input  logic ex_ni,
  input  logic [3:0] ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_write_data,
  memory_stage_banked_if.master bank,
  output logic stall_out,
  output logic err_bank,
  output logic wb_valid,
  output logic wb_wbs,
  output logic wb_ni,
  output logic [3:0] wb_rd,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_calc_data
);
  typedef struct packed {
    logic valid;
    logic wbs;
    logic mem_rd;
    logic mem_wr;
    logic wm;
    logic ni;
    logic [3:0] rd;
    logic [SEL_W-1:0] sel;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
  } stage_t;
  stage_t m, ex;
  logic [SEL_W-1:0] wb_sel;
  logic wb_load, write_done, wait_done, in_range, m_load, m_hold, m_next;
  logic [DATA_W-1:0] q_arr [2**SEL_W];
  assign ex = {ex_valid, ex_wbs, ex_mem_rd, ex_mem_wr, ex_wm, ex_ni, ex_rd, ex_bank_sel, ex_alu_result, ex_write_data};
  assign in_range = 32'(m.sel) < NUM_BANKS;
  assign m_load = m.valid & m.mem_rd;
  assign stall_out = RD_LATENCY == 2 && m_load && !wait_done;
  assign m_hold = stall_in | stall_out;
  // a load waiting on a two-cycle bank is never flushed out of M
  assign m_next = (flush_in & ~stall_out) | ~m_hold;
  assign bank.bank_wdata = m.wdata;
  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    assign bank.bank_addr[i*ADDR_W +: ADDR_W] = m.sel == SEL_W'(i) ? m.alu[ADDR_W-1:0] : '0;
    assign bank.bank_rden[i] = m_load && m.sel == SEL_W'(i);
    assign bank.bank_wren[i] = m.valid && m.mem_wr && m.sel == SEL_W'(i) && !write_done;
  end
  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_q
    if (i < NUM_BANKS) begin : g_in
      assign q_arr[i] = bank.bank_q[i*DATA_W +: DATA_W];
    end else begin : g_out
      assign q_arr[i] = '0;
    end
  end
  assign wb_mem_data = wb_load ? q_arr[wb_sel] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      m <= '0;
      {wb_valid, wb_wbs, wb_ni, wb_rd, wb_sel, wb_load} <= '0;
      wb_calc_data <= '0;
      {write_done, wait_done, err_bank} <= '0;
    end else begin
      if (flush_in && !stall_out) m <= '0;
      else if (!m_hold) m <= ex;
      write_done <= m_next ? 1'b0 : write_done | (|bank.bank_wren);
      wait_done <= m_next ? 1'b0 : wait_done | stall_out;
      err_bank <= err_bank | (m.valid & (m.mem_rd | m.mem_wr) & ~in_range);
      if (!stall_in) begin
        {wb_valid, wb_wbs, wb_ni, wb_rd, wb_sel, wb_load} <= stall_out ? '0 : {m.valid, m.wbs, m.ni, m.rd, m.sel, m_load & in_range};
        wb_calc_data <= stall_out ? '0 : (m.wm ? m.wdata : m.alu);
      end
    end
  end
endmodule
